// File: rtl/piso_pkg.sv
// Shared definitions for the PISO serial transmitter: FSM state encoding
// and a constant-evaluable ceil(log2) helper for counter sizing.
package piso_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Smallest r with (1 << r) >= v; usable in localparam expressions.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Modulo-FLEN frame bit counter with synchronous clear and terminal flag.
// last marks the final bit of a frame; it gates done_tick and the
// back-to-back load window in the transmitter.
module piso_bit_counter #(
  parameter int FLEN = 8,
  parameter int CW   = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic last
);

  logic [CW-1:0] cnt;

  assign last = (cnt == CW'(FLEN - 1));

  // Clear on reset or new-word accept, otherwise count frame bits and wrap.
  always_ff @(posedge clk) begin
    if (reset || clr) cnt <= '0;
    else if (en)      cnt <= last ? '0 : cnt + CW'(1);
  end

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in/serial-out transmitter. Accepts a word on a valid/ready
// handshake and emits it one bit per clk on sout, first bit one cycle after
// accept. A new word may be accepted on the last bit for gapless streaming.
// Optional macro PISO_TX_PARITY_EN appends an even-parity bit to each frame;
// the parity bit rides in an extra shift-register stage so the shifter emits
// it after the data with no special casing.
module piso_shift_tx
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             sout,
  output logic             sout_valid,
  output logic             done_tick
);

`ifdef PISO_TX_PARITY_EN
  localparam int FLEN = WIDTH + 1;
`else
  localparam int FLEN = WIDTH;
`endif
  localparam int CW  = clog2(WIDTH + 1);
  localparam int TXB = MSB_FIRST ? FLEN - 1 : 0;

  state_t          state, state_nxt;
  logic [FLEN-1:0] shreg;
  logic [FLEN-1:0] frame;
  logic            last;
  logic            accept;

  assign accept = load_valid & load_ready;

  // Assemble the outgoing frame so the transmit end holds the first bit.
  always_comb begin
`ifdef PISO_TX_PARITY_EN
    frame = MSB_FIRST ? {load_data, ^load_data} : {^load_data, load_data};
`else
    frame = load_data;
`endif
  end

  piso_bit_counter #(
    .FLEN (FLEN),
    .CW   (CW)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (accept),
    .en    (state == ST_SHIFT),
    .last  (last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state, load window and end-of-frame pulse.
  always_comb begin
    state_nxt  = state;
    load_ready = 1'b0;
    done_tick  = 1'b0;
    case (state)
      ST_IDLE: begin
        load_ready = 1'b1;
        if (load_valid) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        load_ready = last;
        done_tick  = last;
        if (last && !load_valid) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Shift register and registered serial outputs; zero fill behind the data.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg      <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
    end else if (accept) begin
      sout       <= frame[TXB];
      sout_valid <= 1'b1;
      shreg      <= MSB_FIRST ? {frame[FLEN-2:0], 1'b0} : {1'b0, frame[FLEN-1:1]};
    end else if (state == ST_SHIFT && !last) begin
      sout       <= shreg[TXB];
      sout_valid <= 1'b1;
      shreg      <= MSB_FIRST ? {shreg[FLEN-2:0], 1'b0} : {1'b0, shreg[FLEN-1:1]};
    end else begin
      sout       <= 1'b0;
      sout_valid <= 1'b0;
    end
  end

endmodule
